rv32i_trap_sequencer_pipe: RTL
==============================

// Module: rv32i_trap_sequencer_pipe
// PURPOSE
//  Downstream consumer of the interrupt controller handshake (interrupt_state/advance/offset/clear).
//  Stalls fetch and drains the pipeline, then captures the resume PC (EPC) and pulses advance.
//  Redirects fetch to VECTOR_BASE+offset, waits for mret commit, then pulses clear and redirects to EPC.
//  Sits between the interrupt controller and the fetch/hazard unit.
// PARAMETERS
//  XLEN          32            datapath/PC width
//  VECTOR_BASE   32'h0000_0010 handler table base; the controller's offset is already word-scaled (idx<<2)
// PORTS
//  clk_i                 in   1     clock
//  reset_i               in   1     synchronous, active-high reset
//  interrupt_state_i     in   2     controller state: 00 idle, 01 pending, 10 handling
//  interrupt_offset_i    in   XLEN  controller vector offset, valid while state_i==10
//  interrupt_advance_o   out  1     1-cycle pulse: controller 01->10, latches offset
//  clear_interrupt_o     out  1     1-cycle pulse: controller 10->00, retires handled line
//  pipe_empty_i          in   1     no uncommitted instruction in decode..writeback
//  pc_resume_i           in   XLEN  address fetch resumes at after last committed instr
//  mret_commit_i         in   1     mret retired this cycle
//  fetch_stall_o         out  1     hold fetch (no new instr enters pipeline)
//  redirect_valid_o      out  1     1-cycle pulse: fetch loads redirect_pc_o, flushes IF
//  redirect_pc_o         out  XLEN  redirect target; 0 when redirect_valid_o==0
//  epc_o                 out  XLEN  captured resume PC (holds until next capture)
//  in_handler_o          out  1     high from the VECTOR cycle up to and including RETURN
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0, epc_o=0. Takes effect at any state; an in-flight trap is abandoned.
//  States: IDLE, DRAIN, ADVANCE, VECTOR, HANDLER, RETURN, ORPHAN.
//  IDLE: state_i==01 -> DRAIN. state_i==10 (controller has no reset, stuck) -> ORPHAN.
//  DRAIN: fetch_stall_o=1. If pipe_empty_i=1, capture epc_o<=pc_resume_i and go to ADVANCE.
//   A cycle with pipe_empty_i=1 on DRAIN entry still costs 1 cycle (registered capture).
//  ADVANCE: stall=1, interrupt_advance_o=1 for exactly 1 cycle -> VECTOR.
//  VECTOR: stall=1. Requires state_i==10 (offset valid), else waits in VECTOR.
//   Pulses redirect_valid_o with redirect_pc_o=VECTOR_BASE+offset_i (mod 2^XLEN); in_handler_o<=1 -> HANDLER.
//  HANDLER: stall=0, in_handler_o=1. mret_commit_i=1 -> RETURN.
//  RETURN: clear_interrupt_o=1, redirect_valid_o=1, redirect_pc_o=epc_o, stall=1 -> IDLE.
//   State_i is still 10 during the RETURN cycle. IDLE then sees 00, so no re-trigger.
//  ORPHAN: clear_interrupt_o=1 for 1 cycle, no redirect -> IDLE.
//  mret_commit_i outside HANDLER: ignored. It cannot retire while fetch is stalled in DRAIN once the pipe is empty.
//  Latency: state_i 01 with an empty pipe -> redirect_valid_o in 3 cycles (DRAIN, ADVANCE, VECTOR).
//  Back-to-back interrupts: the next trap can start 1 cycle after RETURN (IDLE sees the new 01).
// CONFIGURATION
//  Macro TRAP_LATENCY_STATS_EN
//   Defined: adds ports last_latency_o[15:0] and max_latency_o[15:0].
//    A counter runs from IDLE->DRAIN until VECTOR, inclusive of both, and saturates at 16'hFFFF.
//    On VECTOR it loads last_latency_o and updates max_latency_o if larger.
//    Both reset to 0.
//   Undefined: neither port nor counter exists; all other behaviour is identical.
// STRUCTURE
//  Package rv32i_trap_pkg: FSM state encoding, interrupt_state encodings (ISTATE_IDLE=2'b00,
//   ISTATE_PENDING=2'b01, ISTATE_HANDLING=2'b10), VECTOR_BASE default.
//  Sub-module rv32i_trap_latency_ctr: saturating counter plus max tracker, instantiated only under the macro.
//  FSM, EPC register and redirect mux stay in this module.
// TESTING
//  1 state_i=01, pipe_empty_i=1, pc_resume_i=0x100, offset 0x8 on advance -> advance@+2,
//    redirect 0x18@+3, epc_o=0x100.
//  2 state_i=01, pipe_empty_i low 4 cycles -> fetch_stall_o high throughout, no advance until empty.
//    epc captured on the empty cycle.
//  3 In HANDLER, mret_commit_i=1 -> next cycle clear_interrupt_o=1, redirect_pc_o=0x100, then IDLE with stall=0.
//  4 After reset with state_i held 10 -> single clear_interrupt_o pulse, no redirect_valid_o.
//  5 reset_i asserted in HANDLER -> next cycle all outputs 0, state IDLE; mret afterwards ignored.
//  6 TRAP_LATENCY_STATS_EN: pipe busy 5 cycles -> last_latency_o=8, max_latency_o=8.
//    Next trap with an empty pipe -> last_latency_o=3, max_latency_o stays 8.

Source files
------------

// File: rtl/rv32i_trap_sequencer_pipe_pkg.sv
// Shared encodings for the trap sequencer: FSM states, controller handshake states, vector base.
package rv32i_trap_pkg;

    localparam logic [31:0] VECTOR_BASE_DEF = 32'h0000_0010;

    typedef enum logic [1:0] {
        ISTATE_IDLE     = 2'b00,
        ISTATE_PENDING  = 2'b01,
        ISTATE_HANDLING = 2'b10
    } istate_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ADVANCE,
        S_VECTOR,
        S_HANDLER,
        S_RETURN,
        S_ORPHAN
    } trap_state_e;

endpackage

// File: rtl/rv32i_trap_sequencer_pipe_if.sv
// Handshake between the interrupt controller (master) and the trap sequencer (slave).
interface rv32i_trap_sequencer_pipe_if #(
    parameter int XLEN = 32
);
    logic [1:0]      interrupt_state;
    logic [XLEN-1:0] interrupt_offset;
    logic            interrupt_advance;
    logic            clear_interrupt;

    modport master (
        output interrupt_state, interrupt_offset,
        input  interrupt_advance, clear_interrupt
    );

    modport slave (
        input  interrupt_state, interrupt_offset,
        output interrupt_advance, clear_interrupt
    );
endinterface

// File: rtl/rv32i_trap_latency_ctr.sv
// Saturating trap-entry latency counter with last/max capture.
// Only instantiated when TRAP_LATENCY_STATS_EN is defined.
module rv32i_trap_latency_ctr #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         active_i,
    input  logic         done_i,
    output logic [W-1:0] last_o,
    output logic [W-1:0] max_o
);
    logic [W-1:0] cnt;

    // Starting at 1 makes the first DRAIN cycle part of the count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt <= '0;
        end else if (start_i) begin
            cnt <= W'(1);
        end else if (active_i && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_o <= '0;
            max_o  <= '0;
        end else if (done_i) begin
            last_o <= cnt;
            if (cnt > max_o) max_o <= cnt;
        end
    end
endmodule

// File: rtl/rv32i_trap_sequencer_pipe.sv
// Trap entry/exit sequencer: drains the pipe, hands off to the interrupt controller, redirects fetch.
// Optional latency statistics ports are enabled by defining TRAP_LATENCY_STATS_EN.
//
// state   | meaning
// IDLE    | no trap in progress
// DRAIN   | fetch stalled, waiting for pipe empty, EPC captured on exit
// ADVANCE | one-cycle advance pulse to the controller
// VECTOR  | wait for controller HANDLING, redirect to handler
// HANDLER | handler running, waiting for mret commit
// RETURN  | clear controller, redirect to EPC
// ORPHAN  | controller stuck in HANDLING with no trap; clear it
module rv32i_trap_sequencer_pipe
    import rv32i_trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] VECTOR_BASE = XLEN'(VECTOR_BASE_DEF)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    rv32i_trap_sequencer_pipe_if.slave irq,
    input  logic                  pipe_empty_i,
    input  logic [XLEN-1:0]       pc_resume_i,
    input  logic                  mret_commit_i,
    output logic                  fetch_stall_o,
    output logic                  redirect_valid_o,
    output logic [XLEN-1:0]       redirect_pc_o,
    output logic [XLEN-1:0]       epc_o,
    output logic                  in_handler_o
`ifdef TRAP_LATENCY_STATS_EN
    ,
    output logic [15:0]           last_latency_o,
    output logic [15:0]           max_latency_o
`endif
);
    trap_state_e state, state_nxt;
    logic        handling;

    assign handling = (irq.interrupt_state == ISTATE_HANDLING);

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (irq.interrupt_state == ISTATE_PENDING) state_nxt = S_DRAIN;
                else if (handling)                         state_nxt = S_ORPHAN;
            end
            S_DRAIN:   if (pipe_empty_i)  state_nxt = S_ADVANCE;
            S_ADVANCE: state_nxt = S_VECTOR;
            S_VECTOR:  if (handling)      state_nxt = S_HANDLER;
            S_HANDLER: if (mret_commit_i) state_nxt = S_RETURN;
            S_RETURN:  state_nxt = S_IDLE;
            S_ORPHAN:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_stall_o         = 1'b0;
        redirect_valid_o      = 1'b0;
        redirect_pc_o         = '0;
        in_handler_o          = 1'b0;
        irq.interrupt_advance = 1'b0;
        irq.clear_interrupt   = 1'b0;
        case (state)
            S_DRAIN:   fetch_stall_o = 1'b1;
            S_ADVANCE: begin
                fetch_stall_o         = 1'b1;
                irq.interrupt_advance = 1'b1;
            end
            S_VECTOR: begin
                fetch_stall_o = 1'b1;
                in_handler_o  = 1'b1;
                if (handling) begin
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = VECTOR_BASE + irq.interrupt_offset;
                end
            end
            S_HANDLER: in_handler_o = 1'b1;
            S_RETURN: begin
                fetch_stall_o       = 1'b1;
                in_handler_o        = 1'b1;
                redirect_valid_o    = 1'b1;
                redirect_pc_o       = epc_o;
                irq.clear_interrupt = 1'b1;
            end
            S_ORPHAN:  irq.clear_interrupt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)                              epc_o <= '0;
        else if ((state == S_DRAIN) && pipe_empty_i) epc_o <= pc_resume_i;
    end

`ifdef TRAP_LATENCY_STATS_EN
    rv32i_trap_latency_ctr #(.W(16)) u_lat (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  ((state == S_IDLE) && (state_nxt == S_DRAIN)),
        .active_i ((state == S_DRAIN) || (state == S_ADVANCE) || (state == S_VECTOR)),
        .done_i   ((state == S_VECTOR) && handling),
        .last_o   (last_latency_o),
        .max_o    (max_latency_o)
    );
`endif
endmodule
